// File: rtl/jtag_ir_gen_if.sv
// Signal bundle between a JTAG TAP controller and the instruction register.
// ir_parity_err exists only when JTAG_IR_PARITY_EN is defined.
interface jtag_ir_gen_if #(
    parameter int IR_SIZE = 4
);
    localparam int ST_W = (IR_SIZE > 2) ? IR_SIZE - 2 : 1;

    logic                tlr;
    logic                capture_ir;
    logic                shift_ir;
    logic                update_ir;
    logic                scan_in;
    logic [ST_W-1:0]     status_in;
    logic                scan_out;
    logic [IR_SIZE-1:0]  instr;
    logic                sel_extest;
    logic                sel_sample;
    logic                sel_idcode;
    logic                sel_bypass;
    logic                instr_unknown;
`ifdef JTAG_IR_PARITY_EN
    logic                ir_parity_err;
`endif

    modport master (
        output tlr, capture_ir, shift_ir, update_ir, scan_in, status_in,
        input  scan_out, instr, sel_extest, sel_sample, sel_idcode, sel_bypass,
`ifdef JTAG_IR_PARITY_EN
        input  ir_parity_err,
`endif
        input  instr_unknown
    );

    modport slave (
        input  tlr, capture_ir, shift_ir, update_ir, scan_in, status_in,
        output scan_out, instr, sel_extest, sel_sample, sel_idcode, sel_bypass,
`ifdef JTAG_IR_PARITY_EN
        output ir_parity_err,
`endif
        output instr_unknown
    );
endinterface

// File: rtl/jtag_ir_gen.sv
// JTAG instruction register: capture/shift scan chain, update-loaded output register
// and one-hot instruction decode. Optional odd-parity check via JTAG_IR_PARITY_EN.
module jtag_ir_gen #(
    parameter int                 IR_SIZE   = 4,
    parameter logic [IR_SIZE-1:0] IDCODE_OP = IR_SIZE'(4'b0010),
    parameter logic [IR_SIZE-1:0] SAMPLE_OP = IR_SIZE'(4'b0001)
) (
    input logic           clock,
    input logic           reset,
    jtag_ir_gen_if.slave  ir
);

`ifdef JTAG_IR_PARITY_EN
    localparam int SCAN_LEN = IR_SIZE + 1;
`else
    localparam int SCAN_LEN = IR_SIZE;
`endif

    if (IR_SIZE < 2 || IR_SIZE > 16) begin : g_bad_size
        $error("jtag_ir_gen: IR_SIZE must be within 2..16");
    end
    if (IDCODE_OP == SAMPLE_OP || IDCODE_OP == '0 || IDCODE_OP == '1 ||
        SAMPLE_OP == '0 || SAMPLE_OP == '1) begin : g_bad_opcodes
        $error("jtag_ir_gen: IDCODE_OP/SAMPLE_OP must be distinct and not all-zeros/all-ones");
    end

    logic [SCAN_LEN-1:0] scan_q, scan_d;
    logic [IR_SIZE-1:0]  instr_q, instr_d;
    logic                unknown_q, unknown_d;
    logic                perr_q, perr_d;
    logic [IR_SIZE-1:0]  load_op;
    logic                parity_ok;

    function automatic logic is_known(input logic [IR_SIZE-1:0] op);
        return (op == '0) || (op == '1) || (op == IDCODE_OP) || (op == SAMPLE_OP);
    endfunction

    always_comb begin
        scan_d = scan_q;
        if (ir.capture_ir) begin
            scan_d      = '0;
            scan_d[1:0] = 2'b01;
            for (int unsigned i = 2; i < IR_SIZE; i++) begin
                scan_d[i] = ir.status_in[i-2];
            end
        end else if (ir.shift_ir) begin
            scan_d = {ir.scan_in, scan_q[SCAN_LEN-1:1]};
        end
    end

    // Update samples scan_q (pre-edge content), so a same-cycle capture/shift cannot leak in.
    always_comb begin
        load_op   = scan_q[IR_SIZE-1:0];
`ifdef JTAG_IR_PARITY_EN
        parity_ok = ^scan_q;
`else
        parity_ok = 1'b1;
`endif
        instr_d   = instr_q;
        unknown_d = unknown_q;
        perr_d    = perr_q;
        if (ir.tlr) begin
            instr_d   = IDCODE_OP;
            unknown_d = 1'b0;
            perr_d    = 1'b0;
        end else if (ir.update_ir) begin
            if (parity_ok) begin
                instr_d   = load_op;
                unknown_d = !is_known(load_op);
                perr_d    = 1'b0;
            end else begin
                instr_d   = '1;
                unknown_d = 1'b0;
                perr_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_q    <= '0;
            instr_q   <= IDCODE_OP;
            unknown_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            scan_q    <= scan_d;
            instr_q   <= instr_d;
            unknown_q <= unknown_d;
            perr_q    <= perr_d;
        end
    end

    assign ir.scan_out      = scan_q[0];
    assign ir.instr         = instr_q;
    assign ir.instr_unknown = unknown_q;
    assign ir.sel_extest    = (instr_q == '0);
    assign ir.sel_sample    = (instr_q == SAMPLE_OP);
    assign ir.sel_idcode    = (instr_q == IDCODE_OP);
    assign ir.sel_bypass    = !((instr_q == '0) || (instr_q == SAMPLE_OP) ||
                                (instr_q == IDCODE_OP));
`ifdef JTAG_IR_PARITY_EN
    assign ir.ir_parity_err = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_jtag_ir_gen.sv
// Self-checking bench for jtag_ir_gen: directed scan sequences, a per-cycle model
// compare, and literal expectations. Honours JTAG_IR_PARITY_EN when defined.
module tb_jtag_ir_gen;
    localparam int IR = 4;
    localparam logic [IR-1:0] IDC = 4'b0010;
    localparam logic [IR-1:0] SMP = 4'b0001;
`ifdef JTAG_IR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SL = IR + PAR;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    jtag_ir_gen_if #(.IR_SIZE(IR)) bus ();

    jtag_ir_gen #(.IR_SIZE(IR), .IDCODE_OP(IDC), .SAMPLE_OP(SMP)) dut (
        .clock (clock),
        .reset (reset),
        .ir    (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: scan register as a plain vector, output register as the last accepted opcode
    logic [SL-1:0] m_scan;
    logic [IR-1:0] m_instr;
    logic          m_unk;
    logic          m_perr;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_scan  <= '0;
            m_instr <= IDC;
            m_unk   <= 1'b0;
            m_perr  <= 1'b0;
        end else begin
            if (bus.tlr) begin
                m_instr <= IDC;
                m_unk   <= 1'b0;
                m_perr  <= 1'b0;
            end else if (bus.update_ir) begin
                if (PAR == 1 && ($countones(m_scan) % 2) == 0) begin
                    m_instr <= '1;
                    m_unk   <= 1'b0;
                    m_perr  <= 1'b1;
                end else begin
                    m_instr <= m_scan[IR-1:0];
                    m_unk   <= !(m_scan[IR-1:0] inside {4'b0000, 4'b1111, IDC, SMP});
                    m_perr  <= 1'b0;
                end
            end
            if (bus.capture_ir)
                m_scan <= SL'({bus.status_in, 2'b01});
            else if (bus.shift_ir)
                m_scan <= (m_scan >> 1) | (SL'(bus.scan_in) << (SL - 1));
        end
    end

    function automatic logic [3:0] exp_sel(input logic [IR-1:0] op);
        if (op == 4'b0000) return 4'b1000;
        if (op == SMP)     return 4'b0100;
        if (op == IDC)     return 4'b0010;
        return 4'b0001;
    endfunction

    always @(negedge clock) begin
        check("cmp_instr", 32'(bus.instr), 32'(m_instr));
        check("cmp_sel", 32'({bus.sel_extest, bus.sel_sample, bus.sel_idcode, bus.sel_bypass}),
              32'(exp_sel(m_instr)));
        check("cmp_unknown", 32'(bus.instr_unknown), 32'(m_unk));
        check("cmp_scan_out", 32'(bus.scan_out), 32'(m_scan[0]));
`ifdef JTAG_IR_PARITY_EN
        check("cmp_perr", 32'(bus.ir_parity_err), 32'(m_perr));
`endif
    end

    task automatic step(input logic cap, input logic sh, input logic upd, input logic t,
                        input logic si);
        @(negedge clock);
        bus.capture_ir = cap;
        bus.shift_ir   = sh;
        bus.update_ir  = upd;
        bus.tlr        = t;
        bus.scan_in    = si;
    endtask

    task automatic shift_word(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, v[i]);
    endtask

    // Shifts an opcode, prefixed with a good parity bit when parity is enabled
    task automatic shift_op(input logic [IR-1:0] op);
        logic [31:0] w;
        w = 32'(op);
        if (PAR == 1) w[IR] = ~^op;
        shift_word(w, SL);
    endtask

    task automatic update_and_settle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.capture_ir = 1'b0;
        bus.shift_ir   = 1'b0;
        bus.update_ir  = 1'b0;
        bus.tlr        = 1'b0;
        bus.scan_in    = 1'b0;
        bus.status_in  = 2'b10;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_instr", 32'(bus.instr), 32'h2);
        check("rst_sel_idcode", 32'(bus.sel_idcode), 32'h1);
        check("rst_scan_out", 32'(bus.scan_out), 32'h0);

        // Capture status 2'b10 -> scan ..1001, leaving LSB-first as 1,0,0,1
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cap_out0", 32'(bus.scan_out), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cap_out1", 32'(bus.scan_out), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cap_out2", 32'(bus.scan_out), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cap_out3", 32'(bus.scan_out), 32'h1);

        shift_op(4'b0001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("upd_latency_instr", 32'(bus.instr), 32'h2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sample_instr", 32'(bus.instr), 32'h1);
        check("sample_sel", 32'(bus.sel_sample), 32'h1);

        shift_op(4'b0101);
        update_and_settle();
        check("unk_instr", 32'(bus.instr), 32'h5);
        check("unk_bypass", 32'(bus.sel_bypass), 32'h1);
        check("unk_flag", 32'(bus.instr_unknown), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tlr_instr", 32'(bus.instr), 32'h2);
        check("tlr_unk", 32'(bus.instr_unknown), 32'h0);

        shift_op(4'b1111);
        update_and_settle();
        check("bypass_instr", 32'(bus.instr), 32'hF);
        check("bypass_known", 32'(bus.instr_unknown), 32'h0);

        shift_op(4'b0000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("upd_tlr_instr", 32'(bus.instr), 32'h2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("upd_cap_instr", 32'(bus.instr), 32'h0);
        check("upd_cap_extest", 32'(bus.sel_extest), 32'h1);
        check("upd_cap_bit0", 32'(bus.scan_out), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("upd_cap_bit1", 32'(bus.scan_out), 32'h0);

`ifdef JTAG_IR_PARITY_EN
        shift_word(32'b1_0001, SL);
        update_and_settle();
        check("par_bad_instr", 32'(bus.instr), 32'hF);
        check("par_bad_flag", 32'(bus.ir_parity_err), 32'h1);
        shift_word(32'b0_0001, SL);
        update_and_settle();
        check("par_good_instr", 32'(bus.instr), 32'h1);
        check("par_good_flag", 32'(bus.ir_parity_err), 32'h0);
`endif

        // Reset in the middle of a shift, released between edges
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clock);
        #2 reset = 1'b1;
        bus.shift_ir = 1'b0;
        #10 reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_instr", 32'(bus.instr), 32'h2);
        check("midrst_scan_out", 32'(bus.scan_out), 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_no_update", 32'(bus.sel_idcode), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
